// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl -- single-clock sequencer for the Fibonacci generator and the
// display controller. It produces clock-enable strobes in the clk domain
// instead of divided clocks, and handles run/pause, single-step and clear
// buttons. It also wraps the sequence automatically once fn leaves the
// 4-digit display range.
//
// Optional build macro: FIB_SEQ_CTRL_DEBOUNCE_EN
//   When defined, each synchronized button passes through a stability filter
//   of DEBOUNCE_CYC cycles before edge detection.
//   When undefined, there is no filter and a button edge updates the state on
//   the 3rd clk edge, counting the edge that first samples the button high.
//
// Ports:
//   clk       in   system clock (100 MHz)
//   reset     in   asynchronous active-low reset
//   btn_run   in   async button; rising edge toggles run/pause
//   btn_step  in   async button; rising edge gives one step while paused
//   btn_clr   in   async button; rising edge restarts the sequence
//   fn        in   [13:0] current generator value
//   disp_tick out  one-cycle display refresh enable
//   fib_step  out  one-cycle generator advance enable
//   fib_clr   out  one-cycle generator clear enable
//   running   out  high while the sequencer is running
module fib_seq_ctrl #(
  parameter int unsigned DISP_DIV = 100_000,
  parameter int unsigned STEP_DIV = 100,
  parameter int unsigned LIMIT    = 9999,
  parameter logic        AUTO_RUN = 1'b1
`ifdef FIB_SEQ_CTRL_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_clr,
  input  logic [13:0] fn,
  output logic        disp_tick,
  output logic        fib_step,
  output logic        fib_clr,
  output logic        running
);

  localparam int unsigned A_W = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
  localparam int unsigned B_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [A_W-1:0] A_LAST   = A_W'(DISP_DIV - 1);
  localparam logic [B_W-1:0] B_LAST   = B_W'(STEP_DIV - 1);
  localparam logic [13:0]    FN_LIMIT = 14'(LIMIT);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_PAUSE = 2'd1,
    ST_RUN   = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic           resume, resume_nx;
  logic [A_W-1:0] cnt_a;
  logic [B_W-1:0] cnt_b;

  // Button bit order: [0] run, [1] step, [2] clr.
  logic [2:0] btn_raw;
  logic [2:0] sync_s1, sync_s2;
  logic [2:0] btn_lvl;
  logic [2:0] btn_prev;
  logic [2:0] btn_edge;

  assign btn_raw = {btn_clr, btn_step, btn_run};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_s1  <= '0;
      sync_s2  <= '0;
      btn_prev <= '0;
    end else begin
      sync_s1  <= btn_raw;
      sync_s2  <= sync_s1;
      btn_prev <= btn_lvl;
    end
  end

`ifdef FIB_SEQ_CTRL_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      db_lvl;

  // The debounced level only follows the synchronized level after
  // DEBOUNCE_CYC consecutive samples that differ from it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
      db_lvl <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync_s2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_lvl = db_lvl;
`else
  assign btn_lvl = sync_s2;
`endif

  assign btn_edge = btn_lvl & ~btn_prev;

  logic run_edge, step_edge, clr_edge;
  logic overflow;
  logic tick_now;
  logic step_now;

  assign run_edge  = btn_edge[0];
  assign step_edge = btn_edge[1];
  assign clr_edge  = btn_edge[2];
  assign overflow  = (fn > FN_LIMIT);
  assign tick_now  = (cnt_a == A_LAST);

  // Priority: overflow > clr > run > step; losing edges are simply dropped.
  always_comb begin
    state_nx  = state;
    resume_nx = resume;
    unique case (state)
      ST_CLEAR: state_nx = resume ? ST_RUN : ST_PAUSE;
      ST_PAUSE: begin
        if (overflow || clr_edge) begin
          state_nx = ST_CLEAR;
        end else if (run_edge) begin
          state_nx  = ST_RUN;
          resume_nx = 1'b1;
        end else if (step_edge) begin
          state_nx = ST_STEP;
        end
      end
      ST_RUN: begin
        if (overflow || clr_edge) begin
          state_nx = ST_CLEAR;
        end else if (run_edge) begin
          state_nx  = ST_PAUSE;
          resume_nx = 1'b0;
        end
      end
      ST_STEP:  state_nx = ST_PAUSE;
      default:  state_nx = ST_CLEAR;
    endcase
  end

  // A timed step is only issued if the sequencer stays in RUN on that edge.
  assign step_now = (state == ST_RUN) && (state_nx == ST_RUN) && tick_now &&
                    (cnt_b == B_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_CLEAR;
      resume    <= AUTO_RUN;
      cnt_a     <= '0;
      cnt_b     <= '0;
      disp_tick <= 1'b0;
      fib_step  <= 1'b0;
      fib_clr   <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nx;
      resume    <= resume_nx;
      cnt_a     <= tick_now ? '0 : cnt_a + 1'b1;
      disp_tick <= tick_now;

      if (state == ST_CLEAR) begin
        cnt_b <= '0;
      end else if ((state == ST_RUN) && (state_nx == ST_RUN) && tick_now) begin
        cnt_b <= (cnt_b == B_LAST) ? '0 : cnt_b + 1'b1;
      end

      // Strobes are issued on the edge that enters STEP/CLEAR so they line
      // up with the state change. CLEAR entered from reset has no such edge,
      // so it pulses on its exit instead; fib_clr high marks that pulse as
      // already given.
      fib_step <= step_now || (state_nx == ST_STEP);
      fib_clr  <= (state_nx == ST_CLEAR) || ((state == ST_CLEAR) && !fib_clr);

      // CLEAR lasts one cycle; running reflects where it will resume so an
      // overflow wrap does not blink the indicator.
      running  <= (state_nx == ST_RUN) || ((state_nx == ST_CLEAR) && resume_nx);
    end
  end

endmodule
